arm7tdmi_decoder: RTL and testbench

Pipeline decode stage of the ARM7TDMI core. It registers one fetched instruction (ARM 32-bit, or Thumb 16-bit when thumb_mode=1) and classifies it. It extracts the condition, register, immediate, shift, memory, branch, PSR, coprocessor and Thumb fields. It sits between fetch and execute; condition evaluation against the CPSR is done downstream.

---
 rtl/arm7tdmi_decoder.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_arm7tdmi_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/arm7tdmi_decoder.sv
// ARM7TDMI decode stage: registers one fetched ARM or Thumb instruction and
// breaks it into class, register, immediate, shift, memory, branch, PSR and CP fields.
module arm7tdmi_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [31:0] pc_in,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        thumb_mode,
  output logic [3:0]  condition,
  output logic [3:0]  instr_type,
  output logic [3:0]  alu_op,
  output logic [3:0]  rd,
  output logic [3:0]  rn,
  output logic [3:0]  rm,
  output logic [31:0] immediate,
  output logic        imm_en,
  output logic        set_flags,
  output logic        is_memory,
  output logic        mem_load,
  output logic        mem_byte,
  output logic        mem_pre,
  output logic        mem_up,
  output logic        mem_writeback,
  output logic [31:0] pc_out,
  output logic [1:0]  shift_type,
  output logic [4:0]  shift_amount,
  output logic        shift_reg,
  output logic [3:0]  shift_rs,
  output logic        is_branch,
  output logic [31:0] branch_offset,
  output logic        branch_link,
  output logic        psr_to_reg,
  output logic        psr_spsr,
  output logic        psr_immediate,
  output logic        cp_op,
  output logic [3:0]  cp_num,
  output logic [3:0]  cp_rd,
  output logic [3:0]  cp_rn,
  output logic [3:0]  cp_opcode1,
  output logic [2:0]  cp_opcode2,
  output logic        cp_load,
  output logic [4:0]  thumb_instr_type,
  output logic [2:0]  thumb_rd,
  output logic [2:0]  thumb_rs,
  output logic [2:0]  thumb_rn,
  output logic [7:0]  thumb_imm8,
  output logic [4:0]  thumb_imm5,
  output logic [10:0] thumb_offset11,
  output logic [7:0]  thumb_offset8,
  output logic        decode_valid
);

  typedef enum logic [3:0] {
    ItDataProc  = 4'd0,
    ItMul       = 4'd1,
    ItMulLong   = 4'd2,
    ItSwap      = 4'd3,
    ItBx        = 4'd4,
    ItHalfword  = 4'd5,
    ItPsr       = 4'd6,
    ItSingleDt  = 4'd7,
    ItUndefined = 4'd8,
    ItBlockDt   = 4'd9,
    ItBranch    = 4'd10,
    ItCpDt      = 4'd11,
    ItCdp       = 4'd12,
    ItCpRt      = 4'd13,
    ItSwi       = 4'd14
  } instr_type_e;

  typedef struct packed {
    logic [3:0]  condition;
    logic [3:0]  instr_type;
    logic [3:0]  alu_op;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [31:0] immediate;
    logic        imm_en;
    logic        set_flags;
    logic        is_memory;
    logic        mem_load;
    logic        mem_byte;
    logic        mem_pre;
    logic        mem_up;
    logic        mem_writeback;
    logic [31:0] pc;
    logic [1:0]  shift_type;
    logic [4:0]  shift_amount;
    logic        shift_reg;
    logic [3:0]  shift_rs;
    logic        is_branch;
    logic [31:0] branch_offset;
    logic        branch_link;
    logic        psr_to_reg;
    logic        psr_spsr;
    logic        psr_immediate;
    logic        cp_op;
    logic [3:0]  cp_num;
    logic [3:0]  cp_rd;
    logic [3:0]  cp_rn;
    logic [3:0]  cp_opcode1;
    logic [2:0]  cp_opcode2;
    logic        cp_load;
    logic [4:0]  thumb_instr_type;
    logic [2:0]  thumb_rd;
    logic [2:0]  thumb_rs;
    logic [2:0]  thumb_rn;
    logic [7:0]  thumb_imm8;
    logic [4:0]  thumb_imm5;
    logic [10:0] thumb_offset11;
    logic [7:0]  thumb_offset8;
  } dec_t;

  dec_t        dec_d, dec_q;
  logic        valid_q;
  instr_type_e itype;
  logic [4:0]  t_type;
  logic [31:0] imm8_ext, imm_rot;
  logic [4:0]  rot_amt;

  logic [31:0] ins;
  assign ins = instruction;

  // ARM class; order matters, first match wins.
  always_comb begin
    itype = ItDataProc;
    if (ins[27:22] == 6'b000000 && ins[7:4] == 4'b1001)                  itype = ItMul;
    else if (ins[27:23] == 5'b00001 && ins[7:4] == 4'b1001)              itype = ItMulLong;
    else if (ins[27:23] == 5'b00010 && ins[21:20] == 2'b00 &&
             ins[11:4] == 8'h09)                                         itype = ItSwap;
    else if (ins[27:4] == 24'h12FFF1)                                    itype = ItBx;
    else if (ins[27:25] == 3'b000 && ins[7] && ins[4] && ins[6:5] != 2'b00)
                                                                         itype = ItHalfword;
    else if (ins[27:26] == 2'b00 && ins[24:23] == 2'b10 && !ins[20])     itype = ItPsr;
    else if (ins[27:26] == 2'b00)                                        itype = ItDataProc;
    else if (ins[27:25] == 3'b011 && ins[4])                             itype = ItUndefined;
    else if (ins[27:26] == 2'b01)                                        itype = ItSingleDt;
    else if (ins[27:25] == 3'b100)                                       itype = ItBlockDt;
    else if (ins[27:25] == 3'b101)                                       itype = ItBranch;
    else if (ins[27:25] == 3'b110)                                       itype = ItCpDt;
    else if (ins[27:24] == 4'b1110 && !ins[4])                           itype = ItCdp;
    else if (ins[27:24] == 4'b1110)                                      itype = ItCpRt;
    else                                                                 itype = ItSwi;
  end

  // Thumb format number from the 16-bit encoding; 0 when nothing matches.
  always_comb begin
    t_type = 5'd0;
    if (ins[15:11] == 5'b00011)                             t_type = 5'd2;
    else if (ins[15:13] == 3'b000)                          t_type = 5'd1;
    else if (ins[15:13] == 3'b001)                          t_type = 5'd3;
    else if (ins[15:10] == 6'b010000)                       t_type = 5'd4;
    else if (ins[15:10] == 6'b010001)                       t_type = 5'd5;
    else if (ins[15:11] == 5'b01001)                        t_type = 5'd6;
    else if (ins[15:12] == 4'b0101 && !ins[9])              t_type = 5'd7;
    else if (ins[15:12] == 4'b0101)                         t_type = 5'd8;
    else if (ins[15:13] == 3'b011)                          t_type = 5'd9;
    else if (ins[15:12] == 4'b1000)                         t_type = 5'd10;
    else if (ins[15:12] == 4'b1001)                         t_type = 5'd11;
    else if (ins[15:12] == 4'b1010)                         t_type = 5'd12;
    else if (ins[15:8] == 8'b10110000)                      t_type = 5'd13;
    else if (ins[15:12] == 4'b1011 && ins[10:9] == 2'b10)   t_type = 5'd14;
    else if (ins[15:12] == 4'b1100)                         t_type = 5'd15;
    else if (ins[15:8] == 8'b11011111)                      t_type = 5'd17;
    else if (ins[15:12] == 4'b1101)                         t_type = 5'd16;
    else if (ins[15:11] == 5'b11100)                        t_type = 5'd18;
    else if (ins[15:12] == 4'b1111)                         t_type = 5'd19;
  end

  // Rotated imm8; a shift by 32 yields 0, so rotation 0 needs no special case.
  assign imm8_ext = {24'b0, ins[7:0]};
  assign rot_amt  = {ins[11:8], 1'b0};
  assign imm_rot  = (imm8_ext >> rot_amt) | (imm8_ext << (6'd32 - {1'b0, rot_amt}));

  always_comb begin
    dec_d           = '0;
    dec_d.pc        = pc_in;
    dec_d.condition = 4'hE;
    if (thumb_mode) begin
      dec_d.thumb_instr_type = t_type;
      dec_d.thumb_rd         = ins[2:0];
      dec_d.thumb_rs         = ins[5:3];
      dec_d.thumb_rn         = ins[8:6];
      dec_d.thumb_imm8       = ins[7:0];
      dec_d.thumb_imm5       = ins[10:6];
      dec_d.thumb_offset11   = ins[10:0];
      dec_d.thumb_offset8    = ins[7:0];
      if (t_type == 5'd16) dec_d.condition = ins[11:8];
    end else begin
      dec_d.condition    = ins[31:28];
      dec_d.instr_type   = itype;
      dec_d.alu_op       = ins[24:21];
      dec_d.rd           = ins[15:12];
      dec_d.rn           = ins[19:16];
      dec_d.rm           = ins[3:0];
      dec_d.set_flags    = ins[20];
      dec_d.shift_type   = ins[6:5];
      dec_d.shift_amount = ins[11:7];
      dec_d.shift_rs     = ins[11:8];
      dec_d.shift_reg    = (itype == ItDataProc) && !ins[25] && ins[4];

      unique case (itype)
        ItDataProc, ItPsr: begin
          if (ins[25]) begin
            dec_d.imm_en    = 1'b1;
            dec_d.immediate = imm_rot;
          end
        end
        ItSingleDt: begin
          dec_d.imm_en    = !ins[25];
          dec_d.immediate = {20'b0, ins[11:0]};
        end
        ItHalfword: begin
          dec_d.imm_en    = ins[22];
          dec_d.immediate = {24'b0, ins[11:8], ins[3:0]};
        end
        default: ;
      endcase

      if (itype inside {ItSingleDt, ItHalfword, ItBlockDt, ItSwap}) begin
        dec_d.is_memory     = 1'b1;
        dec_d.mem_load      = ins[20];
        dec_d.mem_byte      = ins[22];
        dec_d.mem_pre       = ins[24];
        dec_d.mem_up        = ins[23];
        dec_d.mem_writeback = ins[21];
      end

      if (itype == ItBranch) begin
        dec_d.is_branch     = 1'b1;
        dec_d.branch_offset = {{6{ins[23]}}, ins[23:0], 2'b00};
        dec_d.branch_link   = ins[24];
      end else if (itype == ItBx) begin
        dec_d.is_branch = 1'b1;
      end

      if (itype == ItPsr) begin
        dec_d.psr_to_reg    = !ins[21];
        dec_d.psr_spsr      = ins[22];
        dec_d.psr_immediate = ins[25];
      end

      if (itype inside {ItCpDt, ItCdp, ItCpRt}) begin
        dec_d.cp_op      = 1'b1;
        dec_d.cp_num     = ins[11:8];
        dec_d.cp_rd      = ins[15:12];
        dec_d.cp_rn      = ins[19:16];
        dec_d.cp_opcode2 = ins[7:5];
        dec_d.cp_load    = ins[20];
        if (itype == ItCdp)       dec_d.cp_opcode1 = ins[23:20];
        else if (itype == ItCpRt) dec_d.cp_opcode1 = {1'b0, ins[23:21]};
      end
    end
  end

  // Flush only drops validity; the stale fields are harmless once invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q           <= '0;
      dec_q.condition <= 4'hE;
      valid_q         <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      dec_q   <= dec_d;
      valid_q <= instr_valid;
    end
  end

  assign condition        = dec_q.condition;
  assign instr_type       = dec_q.instr_type;
  assign alu_op           = dec_q.alu_op;
  assign rd               = dec_q.rd;
  assign rn               = dec_q.rn;
  assign rm               = dec_q.rm;
  assign immediate        = dec_q.immediate;
  assign imm_en           = dec_q.imm_en;
  assign set_flags        = dec_q.set_flags;
  assign is_memory        = dec_q.is_memory;
  assign mem_load         = dec_q.mem_load;
  assign mem_byte         = dec_q.mem_byte;
  assign mem_pre          = dec_q.mem_pre;
  assign mem_up           = dec_q.mem_up;
  assign mem_writeback    = dec_q.mem_writeback;
  assign pc_out           = dec_q.pc;
  assign shift_type       = dec_q.shift_type;
  assign shift_amount     = dec_q.shift_amount;
  assign shift_reg        = dec_q.shift_reg;
  assign shift_rs         = dec_q.shift_rs;
  assign is_branch        = dec_q.is_branch;
  assign branch_offset    = dec_q.branch_offset;
  assign branch_link      = dec_q.branch_link;
  assign psr_to_reg       = dec_q.psr_to_reg;
  assign psr_spsr         = dec_q.psr_spsr;
  assign psr_immediate    = dec_q.psr_immediate;
  assign cp_op            = dec_q.cp_op;
  assign cp_num           = dec_q.cp_num;
  assign cp_rd            = dec_q.cp_rd;
  assign cp_rn            = dec_q.cp_rn;
  assign cp_opcode1       = dec_q.cp_opcode1;
  assign cp_opcode2       = dec_q.cp_opcode2;
  assign cp_load          = dec_q.cp_load;
  assign thumb_instr_type = dec_q.thumb_instr_type;
  assign thumb_rd         = dec_q.thumb_rd;
  assign thumb_rs         = dec_q.thumb_rs;
  assign thumb_rn         = dec_q.thumb_rn;
  assign thumb_imm8       = dec_q.thumb_imm8;
  assign thumb_imm5       = dec_q.thumb_imm5;
  assign thumb_offset11   = dec_q.thumb_offset11;
  assign thumb_offset8    = dec_q.thumb_offset8;
  assign decode_valid     = valid_q;

endmodule

// File: tb/tb_arm7tdmi_decoder.sv
// Scoreboard bench for arm7tdmi_decoder: expectations are queued as each word is
// driven and compared one cycle later against the registered decode.
module tb_arm7tdmi_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction, pc_in;
  logic        instr_valid, stall, flush, thumb_mode;
  logic [3:0]  condition, instr_type, alu_op, rd, rn, rm;
  logic [31:0] immediate, pc_out, branch_offset;
  logic        imm_en, set_flags, is_memory, mem_load, mem_byte, mem_pre, mem_up, mem_writeback;
  logic [1:0]  shift_type;
  logic [4:0]  shift_amount;
  logic        shift_reg, is_branch, branch_link, psr_to_reg, psr_spsr, psr_immediate;
  logic [3:0]  shift_rs, cp_num, cp_rd, cp_rn, cp_opcode1;
  logic        cp_op, cp_load;
  logic [2:0]  cp_opcode2, thumb_rd, thumb_rs, thumb_rn;
  logic [4:0]  thumb_instr_type, thumb_imm5;
  logic [7:0]  thumb_imm8, thumb_offset8;
  logic [10:0] thumb_offset11;
  logic        decode_valid;

  always #5 clk = ~clk;

  arm7tdmi_decoder dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .pc_in(pc_in),
    .instr_valid(instr_valid), .stall(stall), .flush(flush), .thumb_mode(thumb_mode),
    .condition(condition), .instr_type(instr_type), .alu_op(alu_op), .rd(rd), .rn(rn),
    .rm(rm), .immediate(immediate), .imm_en(imm_en), .set_flags(set_flags),
    .is_memory(is_memory), .mem_load(mem_load), .mem_byte(mem_byte), .mem_pre(mem_pre),
    .mem_up(mem_up), .mem_writeback(mem_writeback), .pc_out(pc_out),
    .shift_type(shift_type), .shift_amount(shift_amount), .shift_reg(shift_reg),
    .shift_rs(shift_rs), .is_branch(is_branch), .branch_offset(branch_offset),
    .branch_link(branch_link), .psr_to_reg(psr_to_reg), .psr_spsr(psr_spsr),
    .psr_immediate(psr_immediate), .cp_op(cp_op), .cp_num(cp_num), .cp_rd(cp_rd),
    .cp_rn(cp_rn), .cp_opcode1(cp_opcode1), .cp_opcode2(cp_opcode2), .cp_load(cp_load),
    .thumb_instr_type(thumb_instr_type), .thumb_rd(thumb_rd), .thumb_rs(thumb_rs),
    .thumb_rn(thumb_rn), .thumb_imm8(thumb_imm8), .thumb_imm5(thumb_imm5),
    .thumb_offset11(thumb_offset11), .thumb_offset8(thumb_offset8),
    .decode_valid(decode_valid)
  );

  // kind: 0 = full field check, 1 = condition + valid, 2 = valid only
  typedef struct {
    int          kind;
    string       tag;
    logic [31:0] pc;
    logic [3:0]  cond, itype, alu, rm;
    logic        imm_en;
    logic [31:0] imm;
    logic        br, link;
    logic [31:0] boff;
    logic        ld, up, pre;
    logic [4:0]  ttype;
    logic [7:0]  toff8;
    logic        valid;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [31:0] pc, input logic [3:0] cond,
                              input logic [3:0] itype, input logic [3:0] alu,
                              input logic [3:0] rm_v, input logic ie, input logic [31:0] imm,
                              input logic br, input logic link, input logic [31:0] boff,
                              input logic ld, input logic up, input logic pre,
                              input logic [4:0] tt, input logic [7:0] to8, input logic v);
    exp_t e;
    e.kind = 0; e.tag = tag; e.pc = pc; e.cond = cond; e.itype = itype; e.alu = alu;
    e.rm = rm_v; e.imm_en = ie; e.imm = imm; e.br = br; e.link = link; e.boff = boff;
    e.ld = ld; e.up = up; e.pre = pre; e.ttype = tt; e.toff8 = to8; e.valid = v;
    return e;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic th,
                       input logic v, input logic st, input logic fl, input exp_t e);
    @(negedge clk);
    instruction = ins; pc_in = pc; thumb_mode = th;
    instr_valid = v; stall = st; flush = fl;
    q.push_back(e);
  endtask

  // Monitor: one expectation consumed per edge, sampled 1 time unit after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      check_val({e.tag, ".valid"}, 32'(decode_valid), 32'(e.valid));
      if (e.kind <= 1) check_val({e.tag, ".cond"}, 32'(condition), 32'(e.cond));
      if (e.kind == 0) begin
        check_val({e.tag, ".pc"}, pc_out, e.pc);
        check_val({e.tag, ".type"}, 32'(instr_type), 32'(e.itype));
        check_val({e.tag, ".alu"}, 32'(alu_op), 32'(e.alu));
        check_val({e.tag, ".rm"}, 32'(rm), 32'(e.rm));
        check_val({e.tag, ".imm_en"}, 32'(imm_en), 32'(e.imm_en));
        check_val({e.tag, ".imm"}, immediate, e.imm);
        check_val({e.tag, ".br"}, 32'(is_branch), 32'(e.br));
        check_val({e.tag, ".link"}, 32'(branch_link), 32'(e.link));
        check_val({e.tag, ".boff"}, branch_offset, e.boff);
        check_val({e.tag, ".mem"}, {29'b0, mem_load, mem_up, mem_pre}, {29'b0, e.ld, e.up, e.pre});
        check_val({e.tag, ".ttype"}, 32'(thumb_instr_type), 32'(e.ttype));
        check_val({e.tag, ".toff8"}, 32'(thumb_offset8), 32'(e.toff8));
      end
    end
  end

  initial begin
    exp_t e, held;
    rst_n = 1'b0; instruction = '0; pc_in = '0; instr_valid = 1'b0;
    stall = 1'b0; flush = 1'b0; thumb_mode = 1'b0;
    #12;
    check_val("rst.cond", 32'(condition), 32'hE);
    check_val("rst.type", 32'(instr_type), 32'h0);
    check_val("rst.valid", 32'(decode_valid), 32'h0);
    check_val("rst.imm", immediate, 32'h0);
    check_val("rst.pc", pc_out, 32'h0);
    check_val("rst.br", 32'(is_branch), 32'h0);
    check_val("rst.ttype", 32'(thumb_instr_type), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Top nibble E under [27:24] makes 0x0E000000 a CDP by the class table.
    drive(32'h0E000000, 32'h100, 0, 1, 0, 0,
          mk("cdp0", 32'h100, 4'h0, 4'd12, 4'd0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    drive(32'h02E00000, 32'h104, 0, 1, 0, 0,
          mk("dp_alu7", 32'h104, 4'h0, 4'd0, 4'd7, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    drive(32'hE3A004FF, 32'h108, 0, 1, 0, 0,
          mk("mov_rot", 32'h108, 4'hE, 4'd0, 4'd13, 4'hF, 1, 32'hFF000000,
             0, 0, 0, 0, 0, 0, 0, 0, 1));
    drive(32'hEA000010, 32'h10C, 0, 1, 0, 0,
          mk("b_fwd", 32'h10C, 4'hE, 4'd10, 4'd0, 4'h0, 0, 0, 1, 0, 32'h40,
             0, 0, 0, 0, 0, 1));
    drive(32'hEBFFFFFE, 32'h110, 0, 1, 0, 0,
          mk("bl_back", 32'h110, 4'hE, 4'd10, 4'd15, 4'hE, 0, 0, 1, 1, 32'hFFFFFFF8,
             0, 0, 0, 0, 0, 1));
    drive(32'hE12FFF11, 32'h114, 0, 1, 0, 0,
          mk("bx", 32'h114, 4'hE, 4'd4, 4'd9, 4'h1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    drive(32'hE0010392, 32'h118, 0, 1, 0, 0,
          mk("mul", 32'h118, 4'hE, 4'd1, 4'd0, 4'h2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    drive(32'hE5912004, 32'h11C, 0, 1, 0, 0,
          mk("ldr", 32'h11C, 4'hE, 4'd7, 4'd12, 4'h4, 1, 32'h4, 0, 0, 0, 1, 1, 1, 0, 0, 1));
    drive(32'h0000D0FE, 32'h120, 1, 1, 0, 0,
          mk("t_bcond", 32'h120, 4'h0, 4'd0, 4'd0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,
             5'd16, 8'hFE, 1));
    drive(32'h0000E7FE, 32'h122, 1, 1, 0, 0,
          mk("t_b", 32'h122, 4'hE, 4'd0, 4'd0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,
             5'd18, 8'hFE, 1));

    for (int n = 0; n < 16; n++) begin
      e = mk($sformatf("cond%0d", n), 0, 4'(n), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      e.kind = 1;
      drive({4'(n), 28'hE000000}, 32'(n * 4), 0, 1, 0, 0, e);
    end

    // Stall holds every field while the input moves; flush beats stall.
    held = mk("hold", 32'h200, 4'hE, 4'd10, 4'd0, 4'h0, 0, 0, 1, 0, 32'h40,
              0, 0, 0, 0, 0, 1);
    drive(32'hEA000010, 32'h200, 0, 1, 0, 0, held);
    drive(32'hE5912004, 32'h204, 0, 1, 1, 0, held);
    drive(32'h0000D0FE, 32'h208, 1, 0, 1, 0, held);
    e = held; e.kind = 2; e.valid = 0; e.tag = "flush_stall";
    drive(32'hE0010392, 32'h20C, 0, 1, 1, 1, e);
    drive(32'hE0010392, 32'h210, 0, 0, 0, 0,
          mk("novalid", 32'h210, 4'hE, 4'd1, 4'd0, 4'h2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(32'hE12FFF11, 32'h214, 0, 1, 0, 0,
          mk("recover", 32'h214, 4'hE, 4'd4, 4'd9, 4'h1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));

    repeat (3) @(negedge clk);
    check_val("drain", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
